// File: rtl/aer_pkg.sv
// ---------------------------------------------------------------------------
// aer_pkg
//   Definitions shared by the AER transmit arbiter and the planned
//   receive-side router.
//   - aer_state_e         : handshake controller states
//   - AER_TIMEOUT_CYC_DEF : default REQ-phase timeout in clk cycles
//   - aer_addr_w()        : address width for a given requester count
// ---------------------------------------------------------------------------
package aer_pkg;

  // Handshake controller states. The encoding is visible on the debug port,
  // so keep it stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    REQ   = 2'd2,
    REL   = 2'd3
  } aer_state_e;

  // Default number of cycles to wait in REQ for the receiver to acknowledge.
  localparam int AER_TIMEOUT_CYC_DEF = 1024;

  // Address width for n_req requesters. A single requester still gets a
  // one-bit address so port widths never collapse to zero.
  function automatic int aer_addr_w(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/aer_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aer_rr_arbiter
//   Combinational round-robin search. Returns the first set bit of pending,
//   starting at rr_ptr and wrapping past the top index back to 0.
//
//   Ports
//     pending     in  N_REQ   request bits
//     rr_ptr      in  ADDR_W  index that has highest priority
//     grant_valid out 1       at least one bit of pending is set
//     grant_idx   out ADDR_W  index of the winning bit (0 when none)
// ---------------------------------------------------------------------------
module aer_rr_arbiter
  import aer_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = aer_addr_w(N_REQ)
) (
  input  logic [N_REQ-1:0]  pending,
  input  logic [ADDR_W-1:0] rr_ptr,
  output logic              grant_valid,
  output logic [ADDR_W-1:0] grant_idx
);

  // Walk the offsets from farthest to nearest so the last hit written is the
  // one closest to rr_ptr. Index arithmetic wraps naturally because N_REQ is
  // a power of two and idx is exactly ADDR_W bits wide.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = rr_ptr + ADDR_W'(i);
      if (pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/aer_tx_arbiter.sv
// ---------------------------------------------------------------------------
// aer_tx_arbiter
//   Transmit-side controller for the AER event bus. Spike pulses from N_REQ
//   neurons are captured into sticky pending bits; a round-robin arbiter
//   picks one, its address is driven on aer_addr and a 4-phase req/ack
//   handshake is run with the receiver. On completion the originating neuron
//   gets a one-cycle fs_ack.
//
//   Handshake: aer_req rises one cycle after aer_addr is loaded and stays
//   high until the synchronised acknowledge (ack_s) is seen high; aer_req
//   then falls and the controller waits for ack_s low before the event is
//   retired. aer_addr is held from grant until the controller is back in
//   IDLE. A REQ phase that reaches TIMEOUT_CYC cycles without an ack is
//   abandoned (timeout pulse) and the event stays pending for a retry.
//
//   Ports
//     clk         in  1       system clock
//     reset       in  1       synchronous, active-high reset
//     fs          in  N_REQ   spike fire pulses, one per neuron
//     fs_ack      out N_REQ   one-cycle pulse when a neuron's event completed
//     aer_addr    out ADDR_W  registered event address
//     aer_req     out 1       registered bus request
//     aer_ack     in  1       receiver acknowledge (asynchronous to clk)
//     busy        out 1       controller is not in IDLE
//     timeout     out 1       one-cycle pulse when a REQ phase times out
//     drop_cnt    out CNT_W   saturating count of spikes lost to a set bit
//     dbg_state   out 2       current controller state
//     dbg_pending out N_REQ   current pending bits
// ---------------------------------------------------------------------------
module aer_tx_arbiter
  import aer_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ADDR_W      = aer_addr_w(N_REQ),
  parameter int TIMEOUT_CYC = AER_TIMEOUT_CYC_DEF,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  fs,
  output logic [N_REQ-1:0]  fs_ack,
  output logic [ADDR_W-1:0] aer_addr,
  output logic              aer_req,
  input  logic              aer_ack,
  output logic              busy,
  output logic              timeout,
  output logic [CNT_W-1:0]  drop_cnt,
  output aer_state_e        dbg_state,
  output logic [N_REQ-1:0]  dbg_pending
);

  // The REQ counter only has to reach TIMEOUT_CYC-1.
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  aer_state_e        state;
  logic [N_REQ-1:0]  pending;
  logic [ADDR_W-1:0] rr_ptr;
  logic              ack_s1;
  logic              ack_s;
  logic              done_ok;   // REL entered through an ack, not a timeout
  logic [TO_W-1:0]   to_cnt;

  logic              grant_valid;
  logic [ADDR_W-1:0] grant_idx;
  logic [N_REQ-1:0]  addr_onehot;
  logic              complete;
  logic [N_REQ-1:0]  clr_mask;
  logic              drop_any;
  logic              to_expire;

  // ------------------------------------------------------------------------
  // Acknowledge synchroniser: the only place raw aer_ack is sampled.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else begin
      ack_s1 <= aer_ack;
      ack_s  <= ack_s1;
    end
  end

  // ------------------------------------------------------------------------
  // Arbitration
  // ------------------------------------------------------------------------
  aer_rr_arbiter #(
    .N_REQ  (N_REQ),
    .ADDR_W (ADDR_W)
  ) u_rr (
    .pending     (pending),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // aer_addr doubles as the grant register: it is loaded on grant and not
  // touched again until the controller is back in IDLE.
  assign addr_onehot = N_REQ'(1) << aer_addr;

  // Retirement edge of a successfully acknowledged event.
  assign complete = (state == REL) && !ack_s && done_ok;
  assign clr_mask = complete ? addr_onehot : '0;

  // A spike on a bit that is already pending and not being retired this
  // edge is lost. Several simultaneous losses count once.
  assign drop_any = |(fs & pending & ~clr_mask);

  assign to_expire = (TIMEOUT_CYC > 0) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // ------------------------------------------------------------------------
  // Pending bits and drop counter. Set has priority over clear, so a spike
  // arriving on the retirement edge starts a fresh event.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | fs;
      if (drop_any && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------------
  // Handshake controller
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      aer_req  <= 1'b0;
      aer_addr <= '0;
      rr_ptr   <= '0;
      fs_ack   <= '0;
      timeout  <= 1'b0;
      done_ok  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      fs_ack  <= '0;
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            aer_addr <= grant_idx;
            state    <= SETUP;
          end
        end

        // One cycle of address setup before the request is raised.
        SETUP: begin
          aer_req <= 1'b1;
          to_cnt  <= '0;
          state   <= REQ;
        end

        // Level-sensitive: an ack that is already high counts immediately.
        // An ack on the same edge as the timeout wins.
        REQ: begin
          if (ack_s) begin
            aer_req <= 1'b0;
            done_ok <= 1'b1;
            state   <= REL;
          end else if (to_expire) begin
            aer_req <= 1'b0;
            done_ok <= 1'b0;
            timeout <= 1'b1;
            state   <= REL;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end

        // Wait for the receiver to drop ack. Either way the granted index
        // drops to lowest priority; only a completed event is acknowledged.
        REL: begin
          if (!ack_s) begin
            fs_ack <= clr_mask;
            rr_ptr <= aer_addr + ADDR_W'(1);
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_aer_tx_arbiter.sv
module tb_aer_tx_arbiter
  import aer_pkg::*;
;

  localparam int N     = 4;
  localparam int TO    = 16;
  localparam int CW    = 2;
  localparam int SAT   = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]  fs = '0;
  logic [N-1:0]  fs_ack;
  logic [1:0]    aer_addr;
  logic          aer_req;
  logic          aer_ack;
  logic          busy;
  logic          timeout;
  logic [CW-1:0] drop_cnt;
  aer_state_e    dbg_state;
  logic [N-1:0]  dbg_pending;

  aer_tx_arbiter #(
    .N_REQ       (N),
    .ADDR_W      (2),
    .TIMEOUT_CYC (TO),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fs          (fs),
    .fs_ack      (fs_ack),
    .aer_addr    (aer_addr),
    .aer_req     (aer_req),
    .aer_ack     (aer_ack),
    .busy        (busy),
    .timeout     (timeout),
    .drop_cnt    (drop_cnt),
    .dbg_state   (dbg_state),
    .dbg_pending (dbg_pending)
  );

  // ---------------- receiver model ----------------
  logic auto_ack = 1'b0;
  logic man_ack  = 1'b0;
  bit   rx_manual = 1'b0;
  bit   rx_rand   = 1'b0;
  int   rx_d1 = 3;
  int   rx_d2 = 2;
  assign aer_ack = rx_manual ? man_ack : auto_ack;

  initial begin : receiver
    int d;
    forever begin
      @(negedge clk);
      if (aer_req && !rx_manual) begin
        d = rx_rand ? int'($urandom_range(0, 6)) : rx_d1;
        repeat (d) @(negedge clk);
        #1 auto_ack = 1'b1;
        while (aer_req) @(negedge clk);
        d = rx_rand ? int'($urandom_range(0, 4)) : rx_d2;
        repeat (d) @(negedge clk);
        #1 auto_ack = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];
  int m_rr = 0;
  int m_drop = 0;
  logic [N-1:0] m_pend = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fs = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_rr = 0;
    m_drop = 0;
    m_pend = '0;
  endtask

  // Expected grant order for a batch that all arrives at once: repeatedly take
  // the first set bit at or after the round-robin pointer, which then moves
  // one past the served index.
  function automatic void plan(input logic [N-1:0] mask);
    logic [N-1:0] p;
    int idx;
    p = mask;
    while (p != '0) begin
      for (int i = 0; i < N; i++) begin
        idx = (m_rr + i) % N;
        if (p[idx]) begin
          exp_q.push_back(2'(idx));
          p[idx] = 1'b0;
          m_rr = (idx + 1) % N;
          break;
        end
      end
    end
  endfunction

  // Follow the bus until n_ev events have been acknowledged. Optionally
  // re-fires neurons that are still pending (never the one on the bus) to
  // produce drops.
  task automatic watch(input int n_ev, input int budget, input bit drops);
    int acks;
    int cyc;
    logic prev_req;
    logic [1:0] cur;
    logic [N-1:0] oh;
    logic [N-1:0] cand;
    logic [N-1:0] pick;
    bit saw_to;
    acks = 0;
    cyc = 0;
    prev_req = aer_req;
    cur = aer_addr;
    saw_to = 1'b0;
    while (acks < n_ev && cyc < budget) begin
      @(negedge clk);
      cyc++;
      fs = '0;
      if (timeout) saw_to = 1'b1;
      if (aer_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_event: got addr %0d expected no event", aer_addr);
        end else begin
          cur = exp_q.pop_front();
          check("grant_addr", aer_addr, cur);
        end
      end
      if (aer_req || dbg_state == REL) check("addr_hold", aer_addr, cur);
      if (fs_ack != '0) begin
        oh = 4'b0001 << cur;
        check("fs_ack", fs_ack, oh);
        m_pend &= ~fs_ack;
        acks++;
      end
      prev_req = aer_req;
      if (drops && $urandom_range(0, 2) == 0) begin
        oh = 4'b0001 << aer_addr;
        cand = m_pend & ~oh;
        pick = cand & 4'($urandom_range(1, 15));
        if (pick != '0) begin
          fs = pick;
          if (m_drop < SAT) m_drop++;
        end
      end
    end
    total++;
    if (acks < n_ev) begin
      bad++;
      $display("FAIL watch_budget: got %0d acks expected %0d", acks, n_ev);
    end
    check("no_timeout", saw_to, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit           do_rst;
    logic [N-1:0] mask;
    int           n;
    logic [7:0]   addrs;   // {a3,a2,a1,a0}, a0 served first
  } vec_t;
  vec_t tbl[7];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int c;
    int n;
    bit flag;
    logic [N-1:0] mask;

    tbl[0] = '{do_rst: 1'b1, mask: 4'b0100, n: 1, addrs: 8'b00_00_00_10};
    tbl[1] = '{do_rst: 1'b1, mask: 4'b1111, n: 4, addrs: 8'b11_10_01_00};
    tbl[2] = '{do_rst: 1'b0, mask: 4'b1001, n: 2, addrs: 8'b00_00_11_00};
    tbl[3] = '{do_rst: 1'b0, mask: 4'b0110, n: 2, addrs: 8'b00_00_10_01};
    tbl[4] = '{do_rst: 1'b0, mask: 4'b0011, n: 2, addrs: 8'b00_00_01_00};
    tbl[5] = '{do_rst: 1'b0, mask: 4'b1010, n: 2, addrs: 8'b00_00_01_11};
    tbl[6] = '{do_rst: 1'b0, mask: 4'b0101, n: 2, addrs: 8'b00_00_00_10};

    // ---- reset state ----
    do_reset();
    check("rst_req", aer_req, 0);
    check("rst_addr", aer_addr, 0);
    check("rst_fs_ack", fs_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_pending", dbg_pending, 0);
    check("rst_state", dbg_state, IDLE);

    // ---- single spike latency ----
    rx_d1 = 3;
    rx_d2 = 2;
    fs = 4'b0100;
    @(negedge clk);
    fs = '0;
    check("lat_pend_k", dbg_pending, 4'b0100);
    check("lat_req_k", aer_req, 0);
    @(negedge clk);
    check("lat_addr_k1", aer_addr, 2);
    check("lat_state_k1", dbg_state, SETUP);
    check("lat_req_k1", aer_req, 0);
    @(negedge clk);
    check("lat_req_k2", aer_req, 1);
    for (c = 0; c < 60 && fs_ack == '0; c++) @(negedge clk);
    check("single_fs_ack", fs_ack, 4'b0100);
    @(negedge clk);
    check("single_ack_1cyc", fs_ack, 0);
    check("single_busy", busy, 0);
    check("single_pending", dbg_pending, 0);

    // ---- table: batches and round-robin order ----
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].do_rst) do_reset();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].addrs[2*j +: 2]);
      fs = tbl[i].mask;
      @(negedge clk);
      fs = '0;
      watch(tbl[i].n, 300, 1'b0);
      check("tbl_busy", busy, 0);
      check("tbl_pending", dbg_pending, 0);
      check("tbl_q_empty", exp_q.size(), 0);
    end

    // ---- drops while waiting, then a spike on the completion edge ----
    do_reset();
    rx_manual = 1'b1;
    man_ack = 1'b0;
    fs = 4'b0010;
    @(negedge clk);
    fs = '0;
    @(negedge clk);
    @(negedge clk);
    check("drop_req_up", aer_req, 1);
    fs = 4'b0010; @(negedge clk); fs = '0; @(negedge clk);
    fs = 4'b0010; @(negedge clk); fs = '0; @(negedge clk);
    check("drop_cnt_2", drop_cnt, 2);
    man_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ack_sync_req_m1", aer_req, 1);
    @(negedge clk);
    check("ack_sync_req_m2", aer_req, 0);
    check("ack_sync_rel", dbg_state, REL);
    man_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fs = 4'b0010;
    @(negedge clk);
    fs = '0;
    check("coinc_fs_ack", fs_ack, 4'b0010);
    check("coinc_pending", dbg_pending, 4'b0010);
    check("coinc_drop", drop_cnt, 2);
    check("coinc_state", dbg_state, IDLE);
    rx_manual = 1'b0;
    rx_d1 = 2;
    for (c = 0; c < 20 && !aer_req; c++) @(negedge clk);
    check("coinc_second_req", aer_req, 1);
    check("coinc_second_addr", aer_addr, 1);
    for (c = 0; c < 60 && fs_ack == '0; c++) @(negedge clk);
    check("coinc_second_ack", fs_ack, 4'b0010);
    check("coinc_drop_after", drop_cnt, 2);

    // ---- timeout and retry ----
    do_reset();
    rx_manual = 1'b1;
    man_ack = 1'b0;
    fs = 4'b0010;
    @(negedge clk);
    fs = '0;
    for (c = 0; c < 10 && !aer_req; c++) @(negedge clk);
    check("to_req_up", aer_req, 1);
    n = 0;
    flag = 1'b0;
    while (!timeout && n < 40) begin
      @(negedge clk);
      n++;
      if (fs_ack != '0) flag = 1'b1;
    end
    check("to_latency", n, 16);
    check("to_req_low", aer_req, 0);
    check("to_no_fs_ack", flag, 0);
    check("to_pending", dbg_pending, 4'b0010);
    @(negedge clk);
    check("to_pulse_1cyc", timeout, 0);
    for (c = 0; c < 10 && !aer_req; c++) @(negedge clk);
    check("to_retry_req", aer_req, 1);
    check("to_retry_addr", aer_addr, 1);
    rx_manual = 1'b0;
    for (c = 0; c < 60 && fs_ack == '0; c++) @(negedge clk);
    check("to_retry_ack", fs_ack, 4'b0010);

    // ---- drop counter saturation ----
    do_reset();
    rx_manual = 1'b1;
    man_ack = 1'b0;
    fs = 4'b0001;
    @(negedge clk);
    fs = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      fs = 4'b0001;
      @(negedge clk);
      fs = '0;
      if (k == 2) check("sat_cnt_2", drop_cnt, 2);
      if (k == 5) check("sat_cnt_5", drop_cnt, SAT);
    end
    check("sat_cnt_7", drop_cnt, SAT);

    // ---- reset in the middle of REQ ----
    do_reset();
    rx_manual = 1'b1;
    man_ack = 1'b0;
    fs = 4'b1000;
    @(negedge clk);
    fs = '0;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_up", aer_req, 1);
    fs = 4'b1000;
    @(negedge clk);
    fs = '0;
    check("mid_drop_before", drop_cnt, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_req", aer_req, 0);
    check("mid_pending", dbg_pending, 0);
    check("mid_drop", drop_cnt, 0);
    check("mid_state", dbg_state, IDLE);
    check("mid_fs_ack", fs_ack, 0);
    flag = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (fs_ack != '0 || busy) flag = 1'b1;
    end
    check("mid_quiet", flag, 0);
    rx_manual = 1'b0;

    // ---- randomized batches with drops against the model ----
    rx_rand = 1'b1;
    for (int b = 0; b < 20; b++) begin
      if (b % 5 == 0) do_reset();
      mask = 4'($urandom_range(1, 15));
      plan(mask);
      m_pend = mask;
      fs = mask;
      @(negedge clk);
      fs = '0;
      watch($countones(mask), 600, 1'b1);
      @(negedge clk);
      check("rnd_drop_cnt", drop_cnt, m_drop);
      check("rnd_busy", busy, 0);
      check("rnd_pending", dbg_pending, 0);
      check("rnd_q_empty", exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
